// File: rtl/sobel_pkg.sv
// Shared types, Sobel coefficients and width helpers for the sobel_stream_conv gradient engine.
package sobel_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int GRAD_MARGIN = 3;
    localparam int MIN_LINE_W  = 3;

    // Row index 0 is the oldest line (top of the window), column index 0 the oldest pixel.
    localparam int KX [3][3] = '{'{-1, 0, 1},
                                 '{-2, 0, 2},
                                 '{-1, 0, 1}};
    localparam int KY [3][3] = '{'{-1, -2, -1},
                                 '{ 0,  0,  0},
                                 '{ 1,  2,  1}};

    // Signed width that holds any gradient of unsigned pixels of the given width.
    function automatic int grad_width(input int pix_width);
        return pix_width + GRAD_MARGIN;
    endfunction

    function automatic int clamp_width(input int req_width, input int max_width);
        if (req_width < MIN_LINE_W) return MIN_LINE_W;
        if (req_width > max_width)  return max_width;
        return req_width;
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One-line delay buffer: read-before-write RAM whose address wraps at a runtime line length.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int DATA_W_P = 8,
    parameter int DEPTH_P  = 640,
    parameter int ADDR_W_P = $clog2(DEPTH_P)
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [ADDR_W_P-1:0] len_i,
    input  logic                restart_i,
    input  logic                shift_i,
    input  logic [DATA_W_P-1:0] din_i,
    output logic [DATA_W_P-1:0] dout_o
);

    logic [DATA_W_P-1:0] mem_q [DEPTH_P];
    logic [ADDR_W_P-1:0] ptr_q;
    logic [ADDR_W_P-1:0] ptr_d;
    logic [ADDR_W_P-1:0] addr;

    // A restart beat is column 0 of a new line regardless of where the pointer was.
    assign addr   = restart_i ? '0 : ptr_q;
    assign dout_o = mem_q[addr];

    always_comb begin
        ptr_d = ptr_q;
        if (shift_i) begin
            ptr_d = (addr == len_i - ADDR_W_P'(1)) ? '0 : addr + ADDR_W_P'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // NOTE: the storage array has no reset; every word is rewritten before it is read.
    always_ff @(posedge clk_i) begin
        if (shift_i) begin
            mem_q[addr] <= din_i;
        end
    end

endmodule

// File: rtl/sobel_stream_conv.sv
// Streaming 3x3 Sobel gradient engine with runtime line width and sof/eol tagging.
// Defining SOBEL_MAG_EN adds a saturated |gx|+|gy| output mag_o.
module sobel_stream_conv
    import sobel_pkg::*;
#(
    parameter int WIDTH_P = 8,
    parameter int MAX_W_P = 640,
    parameter int CNT_W_P = $clog2(MAX_W_P)
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [CNT_W_P-1:0]     cfg_width_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [WIDTH_P-1:0]     data_i,
    input  logic                   sof_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [2*WIDTH_P-1:0]   gx_o,
    output logic [2*WIDTH_P-1:0]   gy_o,
    output logic                   sof_o,
    output logic                   eol_o
`ifdef SOBEL_MAG_EN
    ,
    output logic [WIDTH_P-1:0]     mag_o
`endif
);

    localparam int GRAD_W = grad_width(WIDTH_P);
    localparam int OUT_W  = 2 * WIDTH_P;

    typedef logic [WIDTH_P-1:0]        pix_t;
    typedef logic signed [GRAD_W-1:0]  grad_t;

    state_e             state_q;
    logic [CNT_W_P-1:0] width_q;
    logic [CNT_W_P-1:0] col_q;
    logic [1:0]         row_q;
    logic               first_q;
    logic               valid_q;
    logic               sof_q;
    logic               eol_q;
    logic [OUT_W-1:0]   gx_q;
    logic [OUT_W-1:0]   gy_q;
    pix_t               win_q [3][2];

    logic               accept;
    logic               sof_beat;
    logic               in_frame;
    logic               emit;
    logic [CNT_W_P-1:0] w_eff;
    logic [CNT_W_P-1:0] cur_col;
    logic [1:0]         cur_row;
    logic [CNT_W_P-1:0] col_d;
    logic [1:0]         row_d;
    pix_t               lb1_dout;
    pix_t               lb2_dout;
    pix_t               win [3][3];
    grad_t              gx_c;
    grad_t              gy_c;

    assign ready_o  = !valid_q || ready_i;
    assign accept   = valid_i && ready_o;
    assign sof_beat = accept && sof_i;
    assign in_frame = accept && (sof_i || state_q == RUN);

    // A sof beat is pixel (0,0) under the freshly clamped width, whatever the old position was.
    assign w_eff   = sof_i ? CNT_W_P'(clamp_width(int'(cfg_width_i), MAX_W_P)) : width_q;
    assign cur_col = sof_i ? '0 : col_q;
    assign cur_row = sof_i ? '0 : row_q;

    assign col_d = (cur_col == w_eff - CNT_W_P'(1)) ? '0 : cur_col + CNT_W_P'(1);
    assign row_d = (col_d == '0 && cur_row != 2'd2) ? cur_row + 2'd1 : cur_row;
    assign emit  = in_frame && cur_row == 2'd2 && cur_col >= CNT_W_P'(2);

    sobel_line_buf #(
        .DATA_W_P (WIDTH_P),
        .DEPTH_P  (MAX_W_P),
        .ADDR_W_P (CNT_W_P)
    ) u_lb1 (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .len_i     (w_eff),
        .restart_i (sof_i),
        .shift_i   (in_frame),
        .din_i     (data_i),
        .dout_o    (lb1_dout)
    );

    sobel_line_buf #(
        .DATA_W_P (WIDTH_P),
        .DEPTH_P  (MAX_W_P),
        .ADDR_W_P (CNT_W_P)
    ) u_lb2 (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .len_i     (w_eff),
        .restart_i (sof_i),
        .shift_i   (in_frame),
        .din_i     (lb1_dout),
        .dout_o    (lb2_dout)
    );

    // Newest column comes straight from the line buffers and the input port.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) begin
                win[r][c] = win_q[r][c];
            end
        end
        win[0][2] = lb2_dout;
        win[1][2] = lb1_dout;
        win[2][2] = data_i;
    end

    always_comb begin
        gx_c = '0;
        gy_c = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                gx_c = gx_c + grad_t'(KX[r][c]) * grad_t'(win[r][c]);
                gy_c = gy_c + grad_t'(KY[r][c]) * grad_t'(win[r][c]);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            width_q <= CNT_W_P'(MIN_LINE_W);
            col_q   <= '0;
            row_q   <= '0;
            first_q <= 1'b0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            gx_q    <= '0;
            gy_q    <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 2; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            if (in_frame) begin
                state_q <= RUN;
                col_q   <= col_d;
                row_q   <= row_d;
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win[r][1];
                    win_q[r][1] <= win[r][2];
                end
            end
            if (sof_beat) begin
                width_q <= w_eff;
                first_q <= 1'b1;
            end else if (emit) begin
                first_q <= 1'b0;
            end
            if (emit) begin
                valid_q <= 1'b1;
                sof_q   <= first_q;
                eol_q   <= (cur_col == w_eff - CNT_W_P'(1));
                gx_q    <= OUT_W'(gx_c);
                gy_q    <= OUT_W'(gy_c);
            end else if (ready_o) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign valid_o = valid_q;
    assign sof_o   = sof_q;
    assign eol_o   = eol_q;
    assign gx_o    = gx_q;
    assign gy_o    = gy_q;

`ifdef SOBEL_MAG_EN
    logic [GRAD_W-1:0] abs_gx;
    logic [GRAD_W-1:0] abs_gy;
    logic [GRAD_W-1:0] mag_sum;
    pix_t              mag_c;
    pix_t              mag_q;

    // |gx|+|gy| is at most 8*(2^WIDTH_P-1), which still fits GRAD_W unsigned bits.
    always_comb begin
        abs_gx  = gx_c[GRAD_W-1] ? -gx_c : gx_c;
        abs_gy  = gy_c[GRAD_W-1] ? -gy_c : gy_c;
        mag_sum = abs_gx + abs_gy;
        mag_c   = (mag_sum > GRAD_W'({WIDTH_P{1'b1}})) ? '1 : mag_sum[WIDTH_P-1:0];
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mag_q <= '0;
        end else if (emit) begin
            mag_q <= mag_c;
        end
    end

    assign mag_o = mag_q;
`endif

endmodule
